// File: rtl/nn_stream_loader.sv
// ============================================================================
// Module   : nn_stream_loader
// Purpose  : Turns a valid/ready word stream into addressed weight/input
//            write pulses for the neural_network memories.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_stream_loader #(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           mode,
    input  logic                           abort,
    input  logic [BIT_SIZE-1:0]            s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           weight_write_enable,
    output logic                           input_write_enable,
    output logic [$clog2(LAYER_DEPTH)-1:0] layer,
    output logic [$clog2(LAYER_SIZE)-1:0]  node_j,
    output logic [$clog2(LAYER_SIZE)-1:0]  node_k,
    output logic [BIT_SIZE-1:0]            x,
    output logic                           busy,
    output logic                           done
);

    localparam int c_LAYER_W = $clog2(LAYER_DEPTH);
    localparam int c_NODE_W  = $clog2(LAYER_SIZE);
    localparam logic [c_LAYER_W-1:0] c_LAYER_MAX = c_LAYER_W'(LAYER_DEPTH - 1);
    localparam logic [c_NODE_W-1:0]  c_NODE_MAX  = c_NODE_W'(LAYER_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [c_LAYER_W-1:0]  r_cnt_l;
    logic [c_NODE_W-1:0]   r_cnt_j;
    logic [c_NODE_W-1:0]   r_cnt_k;

    logic w_handshake;
    logic w_k_last;
    logic w_j_last;
    logic w_l_last;
    logic w_last;

    // abort masks ready so a word offered alongside it is never consumed
    assign s_ready     = (r_state == ST_LOAD) && !abort;
    assign w_handshake = s_valid && s_ready;
    assign w_k_last    = (r_cnt_k == c_NODE_MAX);
    assign w_j_last    = (r_cnt_j == c_NODE_MAX);
    assign w_l_last    = (r_cnt_l == c_LAYER_MAX);
    assign w_last      = r_mode ? w_k_last : (w_k_last && w_j_last && w_l_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= ST_IDLE;
            r_mode              <= 1'b0;
            r_cnt_l             <= '0;
            r_cnt_j             <= '0;
            r_cnt_k             <= '0;
            weight_write_enable <= 1'b0;
            input_write_enable  <= 1'b0;
            layer               <= '0;
            node_j              <= '0;
            node_k              <= '0;
            x                   <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            weight_write_enable <= 1'b0;
            input_write_enable  <= 1'b0;
            done                <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_mode  <= mode;
                        r_cnt_l <= '0;
                        r_cnt_j <= '0;
                        r_cnt_k <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_handshake) begin
                        weight_write_enable <= !r_mode;
                        input_write_enable  <= r_mode;
                        layer               <= r_cnt_l;
                        node_j              <= r_cnt_j;
                        node_k              <= r_cnt_k;
                        x                   <= s_data;
                        // Nested counters: k fastest, carries into j then layer
                        r_cnt_k <= w_k_last ? '0 : r_cnt_k + c_NODE_W'(1);
                        if (!r_mode && w_k_last) begin
                            r_cnt_j <= w_j_last ? '0 : r_cnt_j + c_NODE_W'(1);
                            if (w_j_last) begin
                                r_cnt_l <= w_l_last ? '0 : r_cnt_l + c_LAYER_W'(1);
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nn_stream_loader.sv
// ============================================================================
// Module   : tb_nn_stream_loader
// Purpose  : Directed/randomised bench for nn_stream_loader with a
//            word-index based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_stream_loader;

    localparam int LS = 4;
    localparam int LD = 4;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [BW-1:0] s_data = '0;
    wire           s_ready;
    wire           weight_write_enable;
    wire           input_write_enable;
    wire [1:0]     layer;
    wire [1:0]     node_j;
    wire [1:0]     node_k;
    wire [BW-1:0]  x;
    wire           busy;
    wire           done;

    nn_stream_loader #(.LAYER_SIZE(LS), .LAYER_DEPTH(LD), .BIT_SIZE(BW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .mode                (mode),
        .abort               (abort),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .weight_write_enable (weight_write_enable),
        .input_write_enable  (input_write_enable),
        .layer               (layer),
        .node_j              (node_j),
        .node_k              (node_k),
        .x                   (x),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    string phase = "reset";

    // Reference model: phase 0 idle, 1 loading, 2 completion cycle
    int   m_state = 0;
    int   m_mode = 0;
    int   m_n = 0;
    int   wcount = 0;
    int   icount = 0;
    logic e_we = 0, e_ie = 0, e_busy = 0, e_done = 0;
    int   e_layer = 0, e_j = 0, e_k = 0, e_x = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("wwe",    {31'd0, weight_write_enable}, {31'd0, e_we});
        chk("iwe",    {31'd0, input_write_enable},  {31'd0, e_ie});
        chk("layer",  {30'd0, layer},  e_layer);
        chk("node_j", {30'd0, node_j}, e_j);
        chk("node_k", {30'd0, node_k}, e_k);
        chk("x",      {16'd0, x},      e_x);
        chk("busy",   {31'd0, busy},   {31'd0, e_busy});
        chk("done",   {31'd0, done},   {31'd0, e_done});
        if (weight_write_enable === 1'b1) wcount++;
        if (input_write_enable === 1'b1) icount++;
    endtask

    task automatic model_step(input logic st, input logic md, input logic ab,
                              input logic v, input logic [BW-1:0] d);
        e_we = 0;
        e_ie = 0;
        e_done = 0;
        case (m_state)
            0: if (st) begin
                m_state = 1; m_mode = md; m_n = 0; e_busy = 1;
            end
            1: if (ab) begin
                m_state = 0; e_busy = 0;
            end else if (v) begin
                if (m_mode == 0) begin
                    e_we = 1;
                    e_layer = m_n / (LS * LS);
                    e_j = (m_n / LS) % LS;
                    e_k = m_n % LS;
                end else begin
                    e_ie = 1; e_layer = 0; e_j = 0; e_k = m_n;
                end
                e_x = d;
                m_n++;
                if (m_n == ((m_mode != 0) ? LS : LD * LS * LS)) begin
                    m_state = 2; e_busy = 0; e_done = 1;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle(input logic st, input logic md, input logic ab,
                         input logic v, input logic [BW-1:0] d);
        @(negedge clk);
        check_outputs();
        start = st; mode = md; abort = ab; s_valid = v; s_data = d;
        #1;
        chk("s_ready", {31'd0, s_ready}, {31'd0, (m_state == 1) && !ab});
        model_step(st, md, ab, v, d);
    endtask

    // pattern: 0 continuous, 1 valid 1,0,0,1 repeating, 2 random; dsel: 0 data=n, 1 random
    task automatic run_load(input logic md, input int pattern, input int dsel, input int base);
        logic v;
        logic [BW-1:0] d;
        wcount = 0;
        icount = 0;
        cycle(1'b1, md, 1'b0, 1'b0, '0);
        for (int c = 0; c < 1000 && m_state != 0; c++) begin
            case (pattern)
                0: v = 1'b1;
                1: v = ((c % 4) == 0) || ((c % 4) == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (dsel == 0) ? BW'(base + m_n) : BW'($urandom);
            cycle(1'b0, 1'b0, 1'b0, v, d);
        end
        chk("idle_after_load", m_state, 0);
        chk("wcount", wcount, md ? 0 : LD * LS * LS);
        chk("icount", icount, md ? LS : 0);
    endtask

    initial begin
        #12;
        phase = "reset";
        chk("wwe",    {31'd0, weight_write_enable}, 32'd0);
        chk("s_ready", {31'd0, s_ready}, 32'd0);
        chk("busy",   {31'd0, busy}, 32'd0);
        chk("x",      {16'd0, x}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        phase = "weight_seq";
        run_load(1'b0, 0, 0, 0);
        phase = "input_seq";
        run_load(1'b1, 0, 0, 'hA0);
        phase = "bubbles";
        run_load(1'b0, 1, 1, 0);
        phase = "input_rand";
        run_load(1'b1, 2, 1, 0);

        phase = "start_abort";
        begin
            bit did_start = 0;
            bit did_abort = 0;
            cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
            for (int c = 0; c < 200 && m_state != 0; c++) begin
                if (m_n == 11 && !did_start) begin
                    did_start = 1;
                    cycle(1'b1, 1'b1, 1'b0, 1'b1, BW'($urandom));
                end else if (m_n == 20 && !did_abort) begin
                    did_abort = 1;
                    cycle(1'b0, 1'b0, 1'b1, 1'b1, BW'($urandom));
                end else begin
                    cycle(1'b0, 1'b0, 1'b0, 1'b1, BW'($urandom));
                end
            end
            chk("aborted_at", m_n, 20);
            cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        end
        phase = "restart";
        run_load(1'b0, 2, 1, 0);

        phase = "reset_mid";
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 50 && m_n < 5; c++) cycle(1'b0, 1'b0, 1'b0, 1'b1, BW'($urandom));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        m_state = 0;
        e_we = 0; e_ie = 0; e_busy = 0; e_done = 0;
        e_layer = 0; e_j = 0; e_k = 0; e_x = 0;
        chk("s_ready_rst", {31'd0, s_ready}, 32'd0);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 1'b0, 1'b1, BW'($urandom));
        phase = "after_reset";
        run_load(1'b1, 2, 1, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nn_stream_loader.md
Name: nn_stream_loader

Overview:
- Upstream feeder for neural_network.
- Accepts a valid/ready word stream and converts it into addressed single-cycle write pulses: weight_write_enable or input_write_enable, plus layer, node_j, node_k and x.
- Loads either the full weight set or one input vector per command.
- Replaces ad-hoc bench/host stimulus driving the network memories.

Parameters:
- LAYER_SIZE, 4, nodes per layer; power of two.
- LAYER_DEPTH, 4, number of layers; power of two.
- BIT_SIZE, 16, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  1  0 = weight load, 1 = input load; captured with start.
- abort  input  1  cancels the current load.
- s_data  input  BIT_SIZE  stream word.
- s_valid  input  1  stream word valid.
- s_ready  output  1  loader can accept a word.
- weight_write_enable  output  1  one-cycle weight write strobe.
- input_write_enable  output  1  one-cycle input write strobe.
- layer  output  $clog2(LAYER_DEPTH)  target layer.
- node_j  output  $clog2(LAYER_SIZE)  target destination node.
- node_k  output  $clog2(LAYER_SIZE)  target source node / input index.
- x  output  BIT_SIZE  write data.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; counters 0.
- States: IDLE, LOAD, DONE.
- IDLE -> LOAD on start=1.
  - Latch mode.
  - Clear counters.
  - busy=1 from the next cycle.
- LOAD:
  - s_ready=1 (combinational from state, independent of s_valid).
  - A handshake occurs when s_valid & s_ready.
  - Each handshake in cycle t gives exactly one write pulse in t+1: the matching enable =1, x = s_data, and the address of the word.
  - Enables are 0 in every cycle without a preceding handshake.
  - layer/node_j/node_k/x hold their last values when no write occurs.
- Weight order (mode 0):
  - Word n maps to layer = n / (LAYER_SIZE^2), node_j = (n / LAYER_SIZE) % LAYER_SIZE, node_k = n % LAYER_SIZE.
  - node_k increments fastest.
  - Total LAYER_DEPTH*LAYER_SIZE^2 words.
- Input order (mode 1):
  - Word n maps to node_k = n, with layer=0 and node_j=0.
  - Total LAYER_SIZE words.
- Counter wrap: node_k wraps to 0 and carries into node_j; node_j wraps to 0 and carries into layer. Nested counters are used, not a divider.
- Final handshake (cycle t):
  - State -> DONE.
  - Cycle t+1: final write pulse and done=1 together; busy=0, s_ready=0.
  - Cycle t+2: IDLE, done=0.
- abort in LOAD:
  - Next state is IDLE.
  - No done pulse.
  - A handshake in the same cycle as abort is not accepted: s_ready is forced 0 when abort=1.
  - No write pulse follows.
- abort in IDLE or DONE is ignored.
- start in LOAD or DONE is ignored; mode is not re-latched.
- start and abort together in IDLE: start wins.
- Reset mid-load: immediate return to IDLE with all outputs 0, including any pending write pulse.
- s_data is not registered beyond one stage; no internal FIFO.

Test Plan:
- Weight load, mode 0:
  - Stimulus: start; stream s_data = n for n = 0..63, continuous valid.
  - Required: 64 weight_write_enable pulses, zero input_write_enable pulses.
  - Pulse n: x=n, layer=n/16, node_j=(n/4)%4, node_k=n%4.
  - done one cycle after the last handshake, together with write pulse 63.
- Input load, mode 1:
  - Stimulus: start; stream 0xA0..0xA3.
  - Required: 4 input_write_enable pulses; node_k = 0..3; layer=0, node_j=0; x = 0xA0..0xA3; done with pulse 3.
- Bubbles:
  - Stimulus: mode 0 load with s_valid toggling 1,0,0,1 per cycle.
  - Required: write pulses only one cycle after each handshake; addresses contiguous with no skips; still exactly 64 pulses.
- Ignored start / abort:
  - Stimulus: start again after word 10 with mode=1.
  - Required: load continues in mode 0 unchanged.
  - Stimulus: abort with s_valid=1 at word 20.
  - Required: no pulse for word 20; IDLE next cycle; no done.
  - Stimulus: new start.
  - Required: addressing restarts at layer=0, node_j=0, node_k=0.
- Reset mid-load:
  - Stimulus: rst=0 asynchronously at word 5, between clock edges.
  - Required: all outputs 0 immediately; after release the loader is in IDLE; s_ready=0 until the next start.
